mips_cpu_muldiv: RTL and testbench
==================================

# mips_cpu_muldiv

Iterative multiply/divide sequencer that owns the HI/LO register pair of the `mips_cpu_harvard` datapath. The decode stage issues MULT, MULTU, DIV, DIVU, MTHI and MTLO to this block. The block runs a 32-step shift-add or restoring-divide sequence and raises `busy` so the core stalls any MFHI/MFLO or further mul/div until the result is committed. It sits beside the ALU and shares its operand buses (rs, rt) and the core's `clk_enable` gating.

## Interface
- No parameters; the width is fixed at 32 bits, per MIPS I.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clk_enable`  in  1  when low, all state, counters and outputs hold.
- `start`  in  1  single-cycle request to begin the operation given by `op`.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `operand_a`  in  32  rs value (multiplicand or dividend); also the write data for MTHI/MTLO.
- `operand_b`  in  32  rt value (multiplier or divisor).
- `write_hi`  in  1  MTHI: HI <= `operand_a`.
- `write_lo`  in  1  MTLO: LO <= `operand_a`.
- `busy`  out  1  high while a sequence is in flight; the core stalls MFHI/MFLO and mul/div while it is high.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO are committed.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- **FSM states:** IDLE, MUL, DIV, FIX.
- **IDLE**
  - `start`=1 latches |a|, |b| and the result sign for signed ops, or raw values for unsigned ops.
  - It clears the 64-bit accumulator and sets the step counter to 0.
  - It goes to MUL when op[1]=0 and to DIV when op[1]=1.
- **MUL:** one shift-add step per cycle on a 64-bit product. The counter increments 0..31. After step 31 the FSM goes to FIX.
- **DIV:** one restoring step per cycle: shift the remainder left, trial-subtract the divisor, set the quotient bit if the result is non-negative. After step 31 the FSM goes to FIX.
- **FIX:** applies sign correction and commits HI/LO, then returns to IDLE.
  - MULT: the product is negated if the operand signs differ.
  - DIV: the quotient is negated if the signs differ; the remainder takes the sign of the dividend (truncation toward zero).
  - Multiply results: HI <= product[63:32], LO <= product[31:0].
  - Divide results: HI <= remainder, LO <= quotient.
- **Divide by zero (`operand_b`=0):** the full latency still runs. HI <= `operand_a`, LO <= 32'hFFFFFFFF for both DIV and DIVU.
- **Signed overflow (DIV of 32'h80000000 by 32'hFFFFFFFF):** LO <= 32'h80000000, HI <= 0.
- **MTHI/MTLO:** accepted only in IDLE and take effect at the next edge. `write_hi` and `write_lo` may be asserted together.
- **Simultaneous events:**
  - `start` and `write_hi`/`write_lo` together in IDLE: `start` wins and the write is dropped.
  - `start`, `write_hi` or `write_lo` while `busy`=1: ignored with no side effects. The core must not issue them.
  - `op` and the operands are sampled only at the accepting edge; later changes have no effect.

## Timing
- **Reset (synchronous):** on the edge with `reset`=1 the state goes to IDLE and `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
  - Reset takes priority over `clk_enable` and over an in-flight sequence. A partial result is discarded and HI/LO read 0.
- **Latency:** let E0 be the edge where `start` is accepted.
  - `busy`=1 after E0.
  - Steps run on edges E1..E32.
  - FIX commits HI/LO on E33; `busy`=0 and `done`=1 after E33.
  - `done`=0 after E34.
  - `busy` is high for exactly 33 enabled cycles; the latency is identical for every operation, including divide by zero.
- **Back-to-back:** a new `start` is accepted on E34 at the earliest (the first IDLE cycle); `done` and the new `busy` may then both be high in the same cycle.
- **Stall:** cycles with `clk_enable`=0 are not counted and stretch the latency one-for-one.
- **Outputs:** `hi` and `lo` are registered and change only at a commit or an MTHI/MTLO edge. They are never combinationally bypassed.

## Test plan
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF → after 33 busy cycles: HI=32'hFFFFFFFE, LO=32'h00000001; `done` pulses once.
- MULT -3 × 7 → HI=32'hFFFFFFFF, LO=32'hFFFFFFEB. Then DIV -7 / 2 → LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1).
- DIVU 100 / 0 → HI=100, LO=32'hFFFFFFFF. DIV 32'h80000000 / 32'hFFFFFFFF → LO=32'h80000000, HI=0.
- MTHI 32'h12345678 then MTLO 32'h9ABCDEF0 in IDLE → values visible next cycle. A `write_hi` pulse during a MULT of 2×3 is ignored: final HI=0, LO=6.
- Start DIVU 1000/10, pulse `clk_enable`=0 for 5 cycles mid-sequence → `busy` high for 38 cycles; LO=100, HI=0.
- Start MULT 5×5, assert `reset` at step 10 → next cycle `busy`=0, `hi`=`lo`=0, and `done` never pulses. A fresh MULT 5×5 then gives LO=25.

Source files
------------

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative multiply/divide sequencer owning the HI/LO pair.
// MULT/MULTU run a 32-step shift-add; DIV/DIVU run a 32-step restoring divide
// on operand magnitudes, followed by one FIX cycle that applies sign
// correction and commits HI/LO. Every operation takes the same latency.
// Ports:
//   clk, reset       core clock, synchronous active-high reset
//   clk_enable       global stall; low holds all state
//   start, op        begin MULT(00)/MULTU(01)/DIV(10)/DIVU(11)
//   operand_a/b      rs/rt operands; operand_a is also MTHI/MTLO data
//   write_hi/lo      MTHI/MTLO strobes, honoured only when idle
//   busy, done       sequence in flight / one-cycle commit pulse
//   hi, lo           architectural HI/LO registers
module mips_cpu_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        write_hi,
  input  logic        write_lo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc;      // product, or remainder in the low half
  logic [2*W-1:0]  mcand;    // shifting multiplicand, or dividend/quotient in the low half
  logic [W-1:0]    mplier;   // shifting multiplier, or divisor
  logic            neg_q, neg_r, div_zero, is_div;

  logic            load, step_mul, step_div, commit, mtx;
  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [2*W-1:0]  acc_add;
  logic [W:0]      rem_sh;
  logic            q_bit;
  logic [W-1:0]    diff;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quo_fix, rem_fix;

  // State register
  always_ff @(posedge clk) begin
    if (reset)           state <= S_IDLE;
    else if (clk_enable) state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = op[1] ? S_DIV : S_MUL;
      S_MUL:   if (cnt == CW'(W - 1)) state_nx = S_FIX;
      S_DIV:   if (cnt == CW'(W - 1)) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Per-state datapath controls; start beats MTHI/MTLO in IDLE
  always_comb begin
    load     = 1'b0;
    mtx      = 1'b0;
    step_mul = 1'b0;
    step_div = 1'b0;
    commit   = 1'b0;
    case (state)
      S_IDLE:  begin load = start; mtx = !start; end
      S_MUL:   step_mul = 1'b1;
      S_DIV:   step_div = 1'b1;
      S_FIX:   commit   = 1'b1;
      default: ;
    endcase
  end

  // Operand magnitudes; op[0]=0 selects the signed variants
  always_comb begin
    a_neg = !op[0] && operand_a[W-1];
    b_neg = !op[0] && operand_b[W-1];
    a_mag = a_neg ? W'(-operand_a) : operand_a;
    b_mag = b_neg ? W'(-operand_b) : operand_b;
  end

  // One shift-add / restoring-divide step and the final sign fix-up
  always_comb begin
    acc_add  = acc + (mplier[0] ? mcand : (2*W)'(0));
    rem_sh   = {acc[W-1:0], mcand[W-1]};
    q_bit    = rem_sh >= {1'b0, mplier};
    diff     = rem_sh[W-1:0] - mplier;  // exact whenever q_bit is set
    prod_fix = neg_q ? (2*W)'(-acc) : acc;
    quo_fix  = neg_q ? W'(-mcand[W-1:0]) : mcand[W-1:0];
    rem_fix  = neg_r ? W'(-acc[W-1:0]) : acc[W-1:0];
  end

  // Datapath and architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
    end else if (clk_enable) begin
      done <= commit;
      if (load) begin
        busy     <= 1'b1;
        cnt      <= '0;
        acc      <= '0;
        mcand    <= {W'(0), a_mag};
        mplier   <= b_mag;
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= a_neg;
        div_zero <= (operand_b == W'(0));
        is_div   <= op[1];
      end else if (step_mul) begin
        acc    <= acc_add;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end else if (step_div) begin
        acc[W-1:0] <= q_bit ? diff : rem_sh[W-1:0];
        mcand      <= {W'(0), mcand[W-2:0], q_bit};
        cnt        <= cnt + CW'(1);
      end else if (commit) begin
        busy <= 1'b0;
        if (is_div) begin
          // Magnitude divide by zero already leaves the dividend as the remainder
          hi <= rem_fix;
          lo <= div_zero ? {W{1'b1}} : quo_fix;
        end else begin
          hi <= prod_fix[2*W-1:W];
          lo <= prod_fix[W-1:0];
        end
      end
      if (mtx && write_hi) hi <= operand_a;
      if (mtx && write_lo) lo <= operand_a;
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed cases with literal
// expectations plus randomized operations, all compared each cycle against
// an arithmetic reference model.
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        reset, clk_enable, start, write_hi, write_lo;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  mips_cpu_muldiv dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .write_hi(write_hi),
    .write_lo(write_lo), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int busy_cnt = 0;
  bit checking = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Architectural result {HI, LO} from plain arithmetic
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint p;
    int sa, sb;
    logic [63:0] r;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'd0: begin p = longint'(sa) * longint'(sb); r = 64'(p); end
      2'd1: r = 64'(a) * 64'(b);
      2'd2: begin
        if (b == 0)                                   r = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
        else                                          r = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else        r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Reference model: a busy countdown of 33 enabled cycles, then commit
  logic        m_busy = 0, m_done = 0;
  logic [31:0] m_hi = 0, m_lo = 0, r_hi = 0, r_lo = 0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_hi = 0; m_lo = 0; m_left = 0;
    end else if (clk_enable) begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_hi = r_hi; m_lo = r_lo;
        end
      end else if (start) begin
        m_busy = 1;
        m_left = 33;
        {r_hi, r_lo} = ref_result(op, operand_a, operand_b);
      end else begin
        if (write_hi) m_hi = operand_a;
        if (write_lo) m_lo = operand_a;
      end
    end
  end

  // Compare process: outputs against the model on every falling edge
  always @(negedge clk) begin
    if (checking) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      if (busy) busy_cnt++;
    end
  end

  // Called at a falling edge; start is accepted at the following rising edge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 0; op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!done) check({name, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input string name);
    busy_cnt = 0;
    issue(o, a, b);
    wait_done(name);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom % 6)
      0: v = 32'h0;
      1: v = 32'hFFFFFFFF;
      2: v = 32'h80000000;
      3: v = $urandom % 16;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    reset = 1; clk_enable = 1; start = 0; write_hi = 0; write_lo = 0;
    op = 0; operand_a = 0; operand_b = 0;
    repeat (2) @(negedge clk);
    checking = 1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    reset = 0;
    @(negedge clk);

    run(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu");
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
    check("multu_busy_cycles", 32'(busy_cnt), 32'd33);
    @(negedge clk);

    run(2'd0, 32'hFFFFFFFD, 32'd7, "mult");
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFEB);
    // back-to-back: issued in the cycle done is high
    run(2'd2, 32'hFFFFFFF9, 32'd2, "div");
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    check("div_busy_cycles", 32'(busy_cnt), 32'd33);

    run(2'd3, 32'd100, 32'd0, "divu0");
    check("divu0_hi", hi, 32'd100);
    check("divu0_lo", lo, 32'hFFFFFFFF);
    check("divu0_busy_cycles", 32'(busy_cnt), 32'd33);
    run(2'd2, 32'h80000000, 32'hFFFFFFFF, "divovf");
    check("divovf_lo", lo, 32'h80000000);
    check("divovf_hi", hi, 32'h0);
    @(negedge clk);

    write_hi = 1; operand_a = 32'h12345678;
    @(negedge clk);
    write_hi = 0;
    check("mthi", hi, 32'h12345678);
    write_lo = 1; operand_a = 32'h9ABCDEF0;
    @(negedge clk);
    write_lo = 0;
    check("mtlo", lo, 32'h9ABCDEF0);
    check("mtlo_hi_kept", hi, 32'h12345678);

    // write_hi held across the accepting edge and the busy period is dropped
    write_hi = 1;
    run(2'd0, 32'd2, 32'd3, "mult_wr");
    write_hi = 0;
    check("mult_wr_hi", hi, 32'h0);
    check("mult_wr_lo", lo, 32'd6);
    @(negedge clk);

    busy_cnt = 0;
    issue(2'd3, 32'd1000, 32'd10);
    repeat (10) @(negedge clk);
    clk_enable = 0;
    repeat (5) @(negedge clk);
    clk_enable = 1;
    wait_done("divu_stall");
    check("divu_stall_busy_cycles", 32'(busy_cnt), 32'd38);
    check("divu_stall_lo", lo, 32'd100);
    check("divu_stall_hi", hi, 32'h0);
    @(negedge clk);

    issue(2'd0, 32'd5, 32'd5);
    repeat (10) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    repeat (40) @(negedge clk);
    check("midrst_no_done_hi", hi, 32'h0);
    run(2'd0, 32'd5, 32'd5, "mult_after_rst");
    check("mult_after_rst_lo", lo, 32'd25);
    check("mult_after_rst_hi", hi, 32'h0);

    // Randomized operations with stalls, idle MTHI/MTLO and ignored strobes
    for (int it = 0; it < 60; it++) begin
      int k;
      repeat ($urandom % 3) begin
        write_hi = ($urandom % 3 == 0); write_lo = ($urandom % 3 == 0);
        operand_a = $urandom;
        @(negedge clk);
      end
      write_hi = 0; write_lo = 0; clk_enable = 1;
      issue(2'($urandom), pick(), pick());
      k = 0;
      while (!done && k < 300) begin
        clk_enable = ($urandom % 10 != 0);
        write_hi   = ($urandom % 8 == 0);
        write_lo   = ($urandom % 8 == 0);
        start      = ($urandom % 8 == 0);
        @(negedge clk);
        k++;
      end
      if (!done) check("rand_timeout", 32'(done), 32'd1);
      start = 0; write_hi = 0; write_lo = 0; clk_enable = 1;
      if ($urandom % 2 == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    checking = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
